// File: rtl/dec_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dec_pkg                                                   |
// | Brief    : Shared types and constants for the hold-timed decoder.    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package dec_pkg;

    localparam int NUM_LINES = 8;
    localparam int CODE_W    = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    function automatic logic [NUM_LINES-1:0] onehot(input logic [CODE_W-1:0] c);
        return NUM_LINES'(1) << c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dec_hold_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dec_hold_cnt                                              |
// | Brief    : Loadable down-counter with zero flag; stops at zero.      |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module dec_hold_cnt #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/dec_bin_oct_hold.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dec_bin_oct_hold                                          |
// | Brief    : Registered 3-to-8 decoder, line held HOLD_CYCLES clocks   |
// |            then one all-off gap. DEC_ACTIVE_LOW_EN: D active-low.    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module dec_bin_oct_hold
    import dec_pkg::*;
#(
    parameter int HOLD_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CODE_W-1:0]    code,
    input  logic                 gs,
    output logic                 ready,
    output logic [NUM_LINES-1:0] D,
    output logic                 done,
    output logic                 ovf
);

    localparam int               CNT_W  = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_LOAD = CNT_W'(HOLD_CYCLES - 1);

`ifdef DEC_ACTIVE_LOW_EN
    localparam logic [NUM_LINES-1:0] c_D_OFF = {NUM_LINES{1'b1}};
`else
    localparam logic [NUM_LINES-1:0] c_D_OFF = '0;
`endif

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_accept;
    logic                 w_cnt_zero;
    logic [NUM_LINES-1:0] w_d_next;
    logic [NUM_LINES-1:0] r_d;
    logic                 r_done;
    logic                 r_ovf;

    assign w_accept = (r_state == IDLE) && gs;

    dec_hold_cnt #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_accept),
        .i_load_val(c_LOAD),
        .i_dec     (r_state == HOLD),
        .o_zero    (w_cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = IDLE;
        case (r_state)
            IDLE:    w_state_next = gs ? HOLD : IDLE;
            HOLD:    w_state_next = w_cnt_zero ? GAP : HOLD;
            GAP:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        ready = (r_state == IDLE);
    end

    // Next line value is computed active-high; polarity is folded in at the register.
    always_comb begin
        w_d_next = '0;
        case (r_state)
            IDLE:    if (gs) w_d_next = onehot(code);
            HOLD:    if (!w_cnt_zero) w_d_next = r_d ^ c_D_OFF;
            default: w_d_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d    <= c_D_OFF;
            r_done <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_d    <= w_d_next ^ c_D_OFF;
            r_done <= (r_state == HOLD) && w_cnt_zero;
            if (gs && (r_state != IDLE)) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign D    = r_d;
    assign done = r_done;
    assign ovf  = r_ovf;

endmodule
`default_nettype wire
